// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds funct3 encodings, FSM states and the iteration count.
package muldiv_pkg;

    localparam int ITER_COUNT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIN
    } state_t;

    function automatic logic a_is_signed(input logic [2:0] f);
        return f == F3_MULH || f == F3_MULHSU
            || f == F3_DIV || f == F3_REM;
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return f == F3_MULH || f == F3_DIV || f == F3_REM;
    endfunction

endpackage

// File: rtl/muldiv_unit_sign_fixup.sv
// Conditional two's-complement negate, used for operand
// magnitudes and for restoring result signs.
module sign_fixup #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and
// restoring divide on magnitudes, one bit per cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t          state;
    logic [1:0]      op;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic            neg_p;
    logic            neg_r;
    logic [5:0]      cnt;

    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_res;

    assign a_neg    = a_is_signed(funct3) & operand_a[XLEN-1];
    assign b_neg    = b_is_signed(funct3) & operand_b[XLEN-1];
    assign div_zero = operand_b == '0;
    assign div_ovf  = !funct3[0]
                   && operand_a == {1'b1, {(XLEN-1){1'b0}}}
                   && operand_b == '1;

    sign_fixup #(.W(XLEN)) u_fix_a (
        .value (operand_a),
        .neg   (a_neg),
        .out   (mag_a)
    );

    sign_fixup #(.W(XLEN)) u_fix_b (
        .value (operand_b),
        .neg   (b_neg),
        .out   (mag_b)
    );

    always_comb begin
        fast_res = '0;
        if (funct3[1])
            fast_res = div_zero ? operand_a : '0;
        else
            fast_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Next accumulator values for one multiply or divide step
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n;
    logic [XLEN-1:0] mul_lo_n;
    logic [XLEN:0]   div_sh;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_hi_n;
    logic [XLEN-1:0] div_lo_n;

    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_n = mul_sum[XLEN:1];
    assign mul_lo_n = {mul_sum[0], lo[XLEN-1:1]};

    assign div_sh   = {hi, lo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_ge   = !div_diff[XLEN];
    assign div_hi_n = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_lo_n = {lo[XLEN-2:0], div_ge};

    logic            is_mul;
    logic [XLEN-1:0] fix_val;
    logic            fix_neg;
    logic [XLEN-1:0] fix_out;
    logic [XLEN-1:0] hi_neg_out;
    logic [XLEN-1:0] hi_fix;
    logic [XLEN-1:0] fin_res;
    logic            last;

    assign is_mul = state == MUL;
    assign last   = cnt == 6'(ITER_COUNT - 1);

    always_comb begin
        fix_val = div_lo_n;
        fix_neg = neg_p;
        unique case (1'b1)
            is_mul: begin
                fix_val = mul_lo_n;
                fix_neg = neg_p;
            end
            !is_mul && op[1]: begin
                fix_val = div_hi_n;
                fix_neg = neg_r;
            end
            !is_mul && !op[1]: begin
                fix_val = div_lo_n;
                fix_neg = neg_p;
            end
        endcase
    end

    sign_fixup #(.W(XLEN)) u_fix_lo (
        .value (fix_val),
        .neg   (fix_neg),
        .out   (fix_out)
    );

    sign_fixup #(.W(XLEN)) u_fix_hi (
        .value (mul_hi_n),
        .neg   (neg_p),
        .out   (hi_neg_out)
    );

    // Upper half of a 64-bit negate only takes the +1 carry when lo is 0
    assign hi_fix  = (neg_p && |mul_lo_n) ? ~mul_hi_n : hi_neg_out;
    assign fin_res = (is_mul && op != 2'b00) ? hi_fix : fix_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            op     <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op    <= funct3[1:0];
                        neg_p <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        hi    <= '0;
                        if (funct3[2] && (div_zero || div_ovf)) begin
                            state  <= FIN;
                            done   <= 1'b1;
                            result <= fast_res;
                        end else if (funct3[2]) begin
                            state <= DIV;
                            lo    <= mag_a;
                            opnd  <= mag_b;
                        end else begin
                            state <= MUL;
                            lo    <= mag_b;
                            opnd  <= mag_a;
                        end
                    end
                end
                MUL: begin
                    hi  <= mul_hi_n;
                    lo  <= mul_lo_n;
                    cnt <= cnt + 6'd1;
                    if (last) begin
                        state  <= FIN;
                        done   <= 1'b1;
                        result <= fin_res;
                    end
                end
                DIV: begin
                    hi  <= div_hi_n;
                    lo  <= div_lo_n;
                    cnt <= cnt + 6'd1;
                    if (last) begin
                        state  <= FIN;
                        done   <= 1'b1;
                        result <= fin_res;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors,
// abort/reset scenarios and random ops against an arithmetic model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .kill      (kill),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_res = '0;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int si, sj;
        logic ovf;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        si = $signed(a);
        sj = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p = '0;
        case (f)
            F3_MUL:    begin p = ua * ub; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(si / sj);
            end
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(si % sj);
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == F3_DIV || f == F3_REM)
            && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: pops the scoreboard on every done, else checks hold
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: result %h, no request pending",
                             result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("latency_cycle", 32'(cyc), 32'(e.at));
                    model_res = e.res;
                end
            end else begin
                chk("result_hold", result, model_res);
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy 1 after 100 cycles, required 0");
        end
    endtask

    task automatic issue_exp(input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] res,
                             input int lat);
        exp_t e;
        wait_idle();
        funct3    = f;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        e.res = res;
        e.at  = cyc + lat;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        issue_exp(f, a, b, ref_model(f, a, b), ref_lat(f, a, b));
    endtask

    task automatic raw_start(input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b);
        funct3    = f;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [2:0] f;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue_exp(F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        issue_exp(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        issue_exp(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        issue_exp(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        issue_exp(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        issue_exp(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        issue_exp(F3_REMU,   32'd7,         32'd2,         32'd1,         33);
        issue_exp(F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        issue_exp(F3_REM,    32'd5,         32'd0,         32'd5,         1);
        issue_exp(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue_exp(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // A fast-path start while busy must not disturb the MUL
        issue_exp(F3_MUL, 32'd1000, 32'd3000, 32'd3000000, 33);
        repeat (3) @(negedge clk);
        raw_start(F3_DIVU, 32'd5, 32'd0);

        // Abort mid-DIV
        wait_idle();
        n = cyc;
        raw_start(F3_DIV, 32'd100, 32'd7);
        while (cyc < n + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_result", result, model_res);
        repeat (3) @(negedge clk);

        // kill wins over start in IDLE
        funct3    = F3_DIVU;
        operand_a = 32'd5;
        operand_b = 32'd0;
        start     = 1'b1;
        kill      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_prio_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Reset mid-DIV
        issue_exp(F3_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, 33);
        wait_idle();
        n = cyc;
        raw_start(F3_DIV, 32'd1234, 32'd5);
        while (cyc < n + 5) @(negedge clk);
        rst = 1'b1;
        model_res = '0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        issue_exp(F3_MUL, 32'd6, 32'd7, 32'd42, 33);

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(f, a, b);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port kill  input  1  abort any in-flight operation.
REQ-006 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port operand_a  input  32  rs1 value from Register_file read_data1.
REQ-008 SHALL have port operand_b  input  32  rs2 value from Register_file read_data2.
REQ-009 SHALL have port busy  output  1  high while an accepted operation is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-011 SHALL have port result  output  32  write-back data toward Register_file write_data.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIN.
REQ-013 SHALL, in IDLE with start=1 and kill=0, latch funct3 and operands, record result signs, load operand magnitudes, clear the iteration counter, and go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-014 SHALL take the fast path for DIV/DIVU/REM/REMU when operand_b=0: go directly to FIN; quotient 0xFFFFFFFF; remainder = operand_a.
REQ-015 SHALL take the fast path for DIV/REM when operand_a=0x80000000 and operand_b=0xFFFFFFFF: go to FIN; quotient 0x80000000; remainder 0.
REQ-016 SHALL execute exactly 32 iterations in MUL (shift-add, 1 bit/cycle, 64-bit accumulator) and in DIV (restoring, 1 quotient bit/cycle), then enter FIN.
REQ-017 SHALL treat signedness as: MULH a,b signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned; DIV/REM signed.
REQ-018 SHALL negate the product if the operand signs differ, negate the quotient if the signs differ, and give the remainder the sign of the dividend.
REQ-019 SHALL select the result: MUL low 32 bits; MULH* high 32 bits; DIV* quotient; REM* remainder.
REQ-020 SHALL, in FIN, assert done for exactly one cycle, update result, and return to IDLE.
REQ-021 SHALL give a latency from the start cycle N of: done at N+33 for the iterative path and N+1 for the fast path; busy high from N+1 through the done cycle inclusive.
REQ-022 SHALL hold result stable from done until the next done.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, on kill=1 in any state, go to IDLE next cycle with no done pulse and result unchanged; kill takes priority over start in the same cycle.
REQ-025 SHALL allow start in the cycle immediately after done.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, force state IDLE, busy=0, done=0, result=0, counter=0, including mid-operation.
REQ-027 SHALL give rst priority over kill and start.

Structure
REQ-028 SHALL place the funct3 encodings, the state enum, and ITER_COUNT=32 in shared package muldiv_pkg.
REQ-029 SHALL use sub-module sign_fixup (32-bit conditional two's-complement negate) for operand magnitude and result sign correction.
REQ-030 SHALL be sized at 120-400 lines of RTL, with no multiplier or divider primitives inferred.

Verification
REQ-031 SHALL cover MUL: a=7, b=-3 (0xFFFFFFFD) -> done at N+33, result 0xFFFFFFEB; MULHU: a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 SHALL cover DIV: a=-7, b=2 -> quotient 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; REMU: a=7, b=2 -> 1.
REQ-033 SHALL cover divide by zero: DIVU a=5, b=0 -> done at N+1, 0xFFFFFFFF; REM a=5, b=0 -> 5.
REQ-034 SHALL cover overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at N+1; REM with the same operands -> 0.
REQ-035 SHALL cover abort: kill at N+10 -> IDLE at N+11, no done, result unchanged; a start during busy is ignored.
REQ-036 SHALL cover reset: rst at N+5 mid-DIV -> busy=0, result=0 next cycle; a fresh MUL 6x7 then yields 42.
